branch_predictor_btb: RTL and testbench

//  Parametrised direct-mapped branch target buffer with per-entry direction counters. It replaces
//  the single-entry jump predictor in the 5-stage pipeline. IF looks up the fetch PC combinationally
//  and receives a predicted next PC. EXE reports each resolved branch or jump. The block flags

---
 rtl/thinpad_bp_pkg.sv | 28 ++
 rtl/bp_sat_ctr.sv | 22 ++
 rtl/branch_predictor_btb.sv | 114 +++++++++++
 tb/tb_branch_predictor_btb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/thinpad_bp_pkg.sv
// Purpose: shared direction-counter constants for the BTB (width chosen by BP_2BIT_CTR_EN).
// Latency: none, constants only.
// Backpressure: not applicable.
package thinpad_bp_pkg;

`ifdef BP_2BIT_CTR_EN
  // Two-bit saturating counter; MSB set means predict taken.
  localparam int CTR_W = 2;
  localparam logic [CTR_W-1:0] STRONG_NT = 2'b00;
  localparam logic [CTR_W-1:0] WEAK_NT   = 2'b01;
  localparam logic [CTR_W-1:0] WEAK_T    = 2'b10;
  localparam logic [CTR_W-1:0] STRONG_T  = 2'b11;
`else
  // One-bit last-outcome counter; the weak and strong states collapse.
  localparam int CTR_W = 1;
  localparam logic [CTR_W-1:0] STRONG_NT = 1'b0;
  localparam logic [CTR_W-1:0] WEAK_NT   = 1'b0;
  localparam logic [CTR_W-1:0] WEAK_T    = 1'b1;
  localparam logic [CTR_W-1:0] STRONG_T  = 1'b1;
`endif

  // Default btb_entry_t field widths (PC/target, index, statistics).
  localparam int PC_W_DFLT   = 16;
  localparam int DEPTH_DFLT  = 16;
  localparam int IDX_W_DFLT  = 4;
  localparam int STAT_W_DFLT = 16;

endpackage

// File: rtl/bp_sat_ctr.sv
// Purpose: next-state of a saturating direction counter from {ctr, taken}.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides whether the result is written.
module bp_sat_ctr
  import thinpad_bp_pkg::*;
(
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_nxt
);

  // Step towards STRONG_T on taken, towards STRONG_NT otherwise, holding at the ends.
  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != STRONG_T) ctr_nxt = ctr + CTR_W'(1);
    end else begin
      if (ctr != STRONG_NT) ctr_nxt = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Purpose: direct-mapped BTB with direction counters, mispredict detect and statistics (BP_2BIT_CTR_EN selects 2-bit counters).
// Latency: lookup and mispredict/redirect are combinational; table and statistics update at the next clk edge.
// Backpressure: exe_hold freezes all state and masks mispredict; the lookup path never stalls.
module branch_predictor_btb
  import thinpad_bp_pkg::*;
#(
  parameter int PC_W   = PC_W_DFLT,
  parameter int DEPTH  = DEPTH_DFLT,
  parameter int IDX_W  = IDX_W_DFLT,
  parameter int STAT_W = STAT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_pc,
  input  logic              exe_valid,
  input  logic [PC_W-1:0]   exe_pc,
  input  logic              exe_taken,
  input  logic [PC_W-1:0]   exe_target,
  input  logic              exe_pred_taken,
  input  logic [PC_W-1:0]   exe_pred_pc,
  input  logic              exe_hold,
  output logic              mispredict,
  output logic [PC_W-1:0]   correct_pc,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_miss
);

  localparam int TAG_W = PC_W - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  // Register array so reset can clear every entry in a single cycle.
  btb_entry_t btb [DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] exe_idx;
  btb_entry_t       if_ent;
  btb_entry_t       exe_ent;
  logic             hit;
  logic             exe_hit;
  logic             upd;
  logic [CTR_W-1:0] ctr_nxt;

  // Fetch-side lookup reads the pre-update entry, giving write-after-read on a same-index update.
  always_comb begin
    if_idx     = if_pc[IDX_W-1:0];
    if_ent     = btb[if_idx];
    hit        = if_ent.valid && (if_ent.tag == if_pc[PC_W-1:IDX_W]);
    pred_taken = hit && if_ent.ctr[CTR_W-1];
    pred_pc    = pred_taken ? if_ent.target : if_pc + PC_W'(1);
  end

  // Resolve-side: entry probe, redirect decision and redirect target.
  always_comb begin
    exe_idx    = exe_pc[IDX_W-1:0];
    exe_ent    = btb[exe_idx];
    exe_hit    = exe_ent.valid && (exe_ent.tag == exe_pc[PC_W-1:IDX_W]);
    upd        = exe_valid && !exe_hold;
    mispredict = upd && ((exe_pred_taken != exe_taken) ||
                         (exe_taken && (exe_pred_pc != exe_target)));
    correct_pc = exe_taken ? exe_target : exe_pc + PC_W'(1);
  end

  bp_sat_ctr u_sat_ctr (
    .ctr     (exe_ent.ctr),
    .taken   (exe_taken),
    .ctr_nxt (ctr_nxt)
  );

  // Table update: allocate on taken miss, train on hit; reset clears all entries and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb[i].valid  <= 1'b0;
        btb[i].tag    <= '0;
        btb[i].target <= '0;
        btb[i].ctr    <= STRONG_NT;
      end
    end else if (upd) begin
      if (exe_taken) begin
        if (exe_hit) begin
          btb[exe_idx].target <= exe_target;
          btb[exe_idx].ctr    <= ctr_nxt;
        end else begin
          btb[exe_idx].valid  <= 1'b1;
          btb[exe_idx].tag    <= exe_pc[PC_W-1:IDX_W];
          btb[exe_idx].target <= exe_target;
          btb[exe_idx].ctr    <= WEAK_T;
        end
      end else if (exe_hit) begin
        btb[exe_idx].ctr <= ctr_nxt;
      end
    end
  end

  // Saturating hit and mispredict counters; a stall blocks hit counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits <= '0;
      stat_miss <= '0;
    end else begin
      if (hit && !exe_hold && (stat_hits != '1)) stat_hits <= stat_hits + STAT_W'(1);
      if (mispredict && (stat_miss != '1))       stat_miss <= stat_miss + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Purpose: self-checking bench for branch_predictor_btb (directed steps plus random traffic vs a reference model).
// Latency: checks combinational outputs mid-cycle, state after each edge.
// Backpressure: exercises exe_hold stalls, including reset during a stall.
module tb_branch_predictor_btb;

`ifdef BP_2BIT_CTR_EN
  localparam bit TWO_BIT = 1'b1;
`else
  localparam bit TWO_BIT = 1'b0;
`endif
  localparam int DEPTH = 16;
  localparam int CMAX  = TWO_BIT ? 3 : 1;
  localparam int WT    = TWO_BIT ? 2 : 1;
  localparam int SMAX  = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_pc;
  logic        pred_taken;
  logic [15:0] pred_pc;
  logic        exe_valid;
  logic [15:0] exe_pc;
  logic        exe_taken;
  logic [15:0] exe_target;
  logic        exe_pred_taken;
  logic [15:0] exe_pred_pc;
  logic        exe_hold;
  logic        mispredict;
  logic [15:0] correct_pc;
  logic [15:0] stat_hits;
  logic [15:0] stat_miss;

  int checks = 0;
  int errors = 0;

  // Reference model: entries as plain integers, counter as an integer 0..CMAX.
  bit m_valid [DEPTH];
  int m_tag   [DEPTH];
  int m_tgt   [DEPTH];
  int m_ctr   [DEPTH];
  int m_hits;
  int m_miss;

  always #5 clk = ~clk;

  branch_predictor_btb dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_pc        (pred_pc),
    .exe_valid      (exe_valid),
    .exe_pc         (exe_pc),
    .exe_taken      (exe_taken),
    .exe_target     (exe_target),
    .exe_pred_taken (exe_pred_taken),
    .exe_pred_pc    (exe_pred_pc),
    .exe_hold       (exe_hold),
    .mispredict     (mispredict),
    .correct_pc     (correct_pc),
    .stat_hits      (stat_hits),
    .stat_miss      (stat_miss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: optionally compare all outputs to the model, clock, then advance the model.
  task automatic step(input bit chk_en);
    int  ii, ei;
    bit  h, pt, mis, eh;
    int  ppc, cpc;
    #1;
    ii  = int'(if_pc) % DEPTH;
    h   = m_valid[ii] && (m_tag[ii] == int'(if_pc) / DEPTH);
    pt  = h && (m_ctr[ii] * 2 > CMAX);
    ppc = pt ? m_tgt[ii] : (int'(if_pc) + 1) % 65536;
    mis = exe_valid && !exe_hold &&
          ((exe_pred_taken != exe_taken) || (exe_taken && (exe_pred_pc != exe_target)));
    cpc = exe_taken ? int'(exe_target) : (int'(exe_pc) + 1) % 65536;
    if (chk_en) begin
      chk("pred_taken", 32'(pred_taken), 32'(pt));
      chk("pred_pc",    32'(pred_pc),    32'(ppc));
      chk("mispredict", 32'(mispredict), 32'(mis));
      chk("correct_pc", 32'(correct_pc), 32'(cpc));
      chk("stat_hits",  32'(stat_hits),  32'(m_hits));
      chk("stat_miss",  32'(stat_miss),  32'(m_miss));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 0;
      end
      m_hits = 0;
      m_miss = 0;
    end else begin
      if (h && !exe_hold) m_hits = (m_hits == SMAX) ? SMAX : m_hits + 1;
      if (mis)            m_miss = (m_miss == SMAX) ? SMAX : m_miss + 1;
      if (exe_valid && !exe_hold) begin
        ei = int'(exe_pc) % DEPTH;
        eh = m_valid[ei] && (m_tag[ei] == int'(exe_pc) / DEPTH);
        if (exe_taken) begin
          if (eh) begin
            m_tgt[ei] = int'(exe_target);
            m_ctr[ei] = (m_ctr[ei] == CMAX) ? CMAX : m_ctr[ei] + 1;
          end else begin
            m_valid[ei] = 1'b1;
            m_tag[ei]   = int'(exe_pc) / DEPTH;
            m_tgt[ei]   = int'(exe_target);
            m_ctr[ei]   = WT;
          end
        end else if (eh) begin
          m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
        end
      end
    end
    #1;
  endtask

  // Pure lookup cycle with directed expectations, then a model-checked clock.
  task automatic look(input logic [15:0] pc, input bit exp_t, input logic [15:0] exp_pc, input string tag);
    if_pc     = pc;
    exe_valid = 1'b0;
    exe_hold  = 1'b0;
    #1;
    chk({tag, "_taken"}, 32'(pred_taken), 32'(exp_t));
    chk({tag, "_pc"},    32'(pred_pc),    32'(exp_pc));
    step(1);
  endtask

  // Resolve cycle with prediction carried down equal to the actual outcome (no redirect).
  task automatic resolve(input logic [15:0] pc, input bit tk, input logic [15:0] tgt);
    if_pc          = 16'h0F00;
    exe_valid      = 1'b1;
    exe_pc         = pc;
    exe_taken      = tk;
    exe_target     = tgt;
    exe_pred_taken = tk;
    exe_pred_pc    = tgt;
    exe_hold       = 1'b0;
    step(1);
  endtask

  function automatic logic [15:0] rpc();
    return 16'($urandom_range(0, 2) * DEPTH + $urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    bit exp_bit;
    rst = 1'b1; if_pc = '0; exe_valid = 1'b0; exe_pc = '0; exe_taken = 1'b0;
    exe_target = '0; exe_pred_taken = 1'b0; exe_pred_pc = '0; exe_hold = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_hits = 0; m_miss = 0;
    @(posedge clk); #1;
    step(0);
    rst = 1'b0;
    #1;
    chk("rst_hits", 32'(stat_hits), 32'd0);
    chk("rst_miss", 32'(stat_miss), 32'd0);

    // Empty table: every fetch falls through.
    for (int p = 0; p < 256; p++) begin
      if_pc = 16'(p);
      step(1);
    end
    look(16'h0080, 1'b0, 16'h0081, "sweep_end");

    // Taken branch allocates; next lookup predicts its target.
    resolve(16'h0012, 1'b1, 16'h0040);
    look(16'h0012, 1'b1, 16'h0040, "alloc");

    // Not-taken training: first one flips the prediction in both modes.
    resolve(16'h0012, 1'b0, 16'h0000);
    look(16'h0012, 1'b0, 16'h0013, "nt1");
    resolve(16'h0012, 1'b0, 16'h0000);
    resolve(16'h0012, 1'b0, 16'h0000);
    look(16'h0012, 1'b0, 16'h0013, "nt3");
    // Entry survived: a taken hit only trains (2-bit: STRONG_NT -> WEAK_NT, still not taken).
    resolve(16'h0012, 1'b1, 16'h0040);
    exp_bit = !TWO_BIT;
    look(16'h0012, exp_bit, exp_bit ? 16'h0040 : 16'h0013, "kept_valid");

    // Tag alias overwrites the entry.
    resolve(16'h0112, 1'b1, 16'h0080);
    look(16'h0012, 1'b0, 16'h0013, "alias_old");
    look(16'h0112, 1'b1, 16'h0080, "alias_new");

    // Wrong target under a stall: no redirect, no state change.
    if_pc = 16'h0F00; exe_valid = 1'b1; exe_pc = 16'h0012; exe_taken = 1'b1;
    exe_target = 16'h0050; exe_pred_taken = 1'b1; exe_pred_pc = 16'h0040; exe_hold = 1'b1;
    #1;
    chk("hold_mis", 32'(mispredict), 32'd0);
    step(1);
    look(16'h0112, 1'b1, 16'h0080, "hold_keep");
    // Same stimulus without the stall redirects.
    if_pc = 16'h0F00; exe_valid = 1'b1; exe_pc = 16'h0012; exe_taken = 1'b1;
    exe_target = 16'h0050; exe_pred_taken = 1'b1; exe_pred_pc = 16'h0040; exe_hold = 1'b0;
    #1;
    chk("mis", 32'(mispredict), 32'd1);
    chk("mis_pc", 32'(correct_pc), 32'h0050);
    step(1);

    // Same-index lookup and allocate in one cycle: lookup sees the old (empty) entry.
    if_pc = 16'h0025; exe_valid = 1'b1; exe_pc = 16'h0025; exe_taken = 1'b1;
    exe_target = 16'h0099; exe_pred_taken = 1'b0; exe_pred_pc = 16'h0026; exe_hold = 1'b0;
    #1;
    chk("war_taken", 32'(pred_taken), 32'd0);
    step(1);
    look(16'h0025, 1'b1, 16'h0099, "war_after");

    // Reset beats a simultaneous update; reset during a stall drops the update.
    rst = 1'b1; if_pc = 16'h0F00; exe_valid = 1'b1; exe_pc = 16'h0033; exe_taken = 1'b1;
    exe_target = 16'h0077; exe_pred_taken = 1'b1; exe_pred_pc = 16'h0077; exe_hold = 1'b0;
    step(1);
    exe_hold = 1'b1;
    step(1);
    rst = 1'b0;
    look(16'h0033, 1'b0, 16'h0034, "rst_win");
    look(16'h0025, 1'b0, 16'h0026, "rst_clear");

    // Random traffic over a few aliasing tags.
    for (int n = 0; n < 2000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      if_pc          = rpc();
      exe_valid      = 1'($urandom_range(0, 1));
      exe_pc         = rpc();
      exe_taken      = 1'($urandom_range(0, 1));
      exe_target     = 16'($urandom);
      exe_pred_taken = 1'($urandom_range(0, 1));
      exe_pred_pc    = ($urandom_range(0, 1) == 1) ? exe_target : 16'($urandom);
      exe_hold       = ($urandom_range(0, 3) == 0);
      step(1);
    end
    rst = 1'b0;

    // Drive stat_miss into saturation.
    if_pc = 16'h0F00; exe_valid = 1'b1; exe_pc = 16'h0005; exe_taken = 1'b0;
    exe_target = '0; exe_pred_taken = 1'b1; exe_pred_pc = '0; exe_hold = 1'b0;
    for (int n = 0; n < 65540; n++) step(0);
    #1;
    chk("miss_sat", 32'(stat_miss), 32'h0000FFFF);
    step(1);
    chk("miss_sat_hold", 32'(stat_miss), 32'h0000FFFF);

    // PC wrap on a miss.
    look(16'hFFFF, 1'b0, 16'h0000, "wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
